// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and width defaults for the data-memory arbiter
package mem_arb_pkg;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, CRD = 2'd1, XRD = 2'd2} state_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_EXT = 1'b1} owner_t;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-request round-robin picker; req[0]=CPU, req[1]=EXT, ties go to the non-last winner
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    owner_t last;
    always_comb begin
        gnt[0] = req[0] & (~req[1] | (last == OWN_EXT));
        gnt[1] = req[1] & (~req[0] | (last == OWN_CPU));
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) last <= OWN_EXT;
        else if (|gnt) last <= gnt[1] ? OWN_EXT : OWN_CPU;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one sync-read memory port between CPU and an external requester.
// Define MEM_ARB_WRITE_BUF_EN for a one-entry posted buffer for CPU writes that lose arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    state_t state, state_nxt;
    logic [1:0] req, gnt;
    logic idle, drain, cap, cpu_fwd, fwd, wb_v;
    logic [AW-1:0] wb_a;
    logic [DW-1:0] wb_d, fwd_d;
    assign idle = state == IDLE;
    assign drain = idle & wb_v;
    assign req = {ext_req, cpu_req} & {2{idle & ~wb_v}};
    assign cpu_fwd = drain & cpu_req & ~cpu_we & (cpu_addr == wb_a);
    rr_arb2 u_arb (.clk(clk), .rst(rst), .req(req), .gnt(gnt));
`ifdef MEM_ARB_WRITE_BUF_EN
    assign cap = gnt[1] & cpu_req & cpu_we;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wb_v  <= 1'b0;
            wb_a  <= '0;
            wb_d  <= '0;
            fwd   <= 1'b0;
            fwd_d <= '0;
        end else begin
            if (drain) wb_v <= 1'b0;
            else if (cap) begin
                wb_v <= 1'b1;
                wb_a <= cpu_addr;
                wb_d <= cpu_wdata;
            end
            fwd   <= cpu_fwd;
            fwd_d <= wb_d;
        end
`else
    assign cap   = 1'b0;
    assign wb_v  = 1'b0;
    assign wb_a  = '0;
    assign wb_d  = '0;
    assign fwd   = 1'b0;
    assign fwd_d = '0;
`endif
    always_comb begin
        state_nxt  = state;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_stall  = 1'b0;
        cpu_rdata  = '0;
        ext_gnt    = 1'b0;
        ext_rvalid = 1'b0;
        ext_rdata  = '0;
        // outputs are forced quiet while reset is held, whatever the inputs do
        if (rst) begin
            case (state)
                IDLE: begin
                    if (drain) begin
                        mem_we    = 1'b1;
                        mem_addr  = wb_a;
                        mem_wdata = wb_d;
                        cpu_stall = cpu_req;
                        state_nxt = cpu_fwd ? CRD : IDLE;
                    end else begin
                        mem_addr  = gnt[1] ? ext_addr : cpu_addr;
                        mem_wdata = gnt[1] ? ext_wdata : cpu_wdata;
                        mem_we    = gnt[0] ? cpu_we : gnt[1] & ext_we;
                        ext_gnt   = gnt[1];
                        cpu_stall = cpu_req & ~(gnt[0] & cpu_we) & ~cap;
                        state_nxt = (gnt[0] & ~cpu_we) ? CRD : (gnt[1] & ~ext_we) ? XRD : IDLE;
                    end
                end
                CRD: begin
                    cpu_rdata = fwd ? fwd_d : mem_rdata;
                    state_nxt = IDLE;
                end
                XRD: begin
                    ext_rdata  = mem_rdata;
                    ext_rvalid = 1'b1;
                    cpu_stall  = cpu_req;
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nxt;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus, per-cycle reference model plus literal spot checks
module tb_mem_arbiter;
    logic        clk, rst;
    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
    logic [15:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_stall, ext_gnt, ext_rvalid, mem_we;
    int          checks = 0, errors = 0;
    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );
    initial clk = 0;
    always #5 clk = ~clk;

    logic [15:0] tmem [256];
    logic [15:0] rmem [256];
    initial for (int i = 0; i < 256; i++) begin
        tmem[i] = 16'hA000 ^ 16'(i);
        rmem[i] = 16'hA000 ^ 16'(i);
    end
    always @(posedge clk) begin
        if (mem_we) tmem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= tmem[mem_addr[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: pend 0=free, 1=CPU read data due, 2=EXT read data due
    int          m_pend = 0, n_pend = 0;
    bit          m_last = 1, n_last = 1, m_bv = 0, n_bv = 0, m_fwd = 0, n_fwd = 0, n_w = 0;
    logic [7:0]  m_ra, n_ra, n_wa;
    logic [15:0] m_ba, n_ba, m_bd, n_bd, m_fd, n_fd, n_wd;
    always @(negedge clk) begin : cmp
        bit cw, ew, cap, fw, xwe;
        n_pend = 0; n_last = m_last; n_bv = m_bv; n_ba = m_ba; n_bd = m_bd;
        n_fwd = 0; n_fd = m_fd; n_ra = m_ra; n_w = 0; n_wa = 0; n_wd = 0;
        if (!rst) begin
            chk("rst_stall", cpu_stall, 0); chk("rst_we", mem_we, 0);
            chk("rst_gnt", ext_gnt, 0); chk("rst_rvalid", ext_rvalid, 0);
            chk("rst_crd", cpu_rdata, 0); chk("rst_xrd", ext_rdata, 0);
            chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
            n_last = 1; n_bv = 0;
        end else if (m_pend == 1) begin
            chk("crd_data", cpu_rdata, m_fwd ? m_fd : rmem[m_ra]);
            chk("crd_stall", cpu_stall, 0); chk("crd_we", mem_we, 0);
            chk("crd_gnt", ext_gnt, 0); chk("crd_rvalid", ext_rvalid, 0);
        end else if (m_pend == 2) begin
            chk("xrd_rvalid", ext_rvalid, 1); chk("xrd_data", ext_rdata, rmem[m_ra]);
            chk("xrd_stall", cpu_stall, cpu_req); chk("xrd_we", mem_we, 0);
            chk("xrd_gnt", ext_gnt, 0);
        end else if (m_bv) begin
            fw = cpu_req && !cpu_we && cpu_addr == m_ba;
            chk("drn_we", mem_we, 1); chk("drn_addr", mem_addr, m_ba);
            chk("drn_wdata", mem_wdata, m_bd); chk("drn_stall", cpu_stall, cpu_req);
            chk("drn_gnt", ext_gnt, 0); chk("drn_rvalid", ext_rvalid, 0);
            n_w = 1; n_wa = m_ba[7:0]; n_wd = m_bd; n_bv = 0;
            if (fw) begin n_pend = 1; n_fwd = 1; n_fd = m_bd; end
        end else begin
            ew = ext_req && (!cpu_req || !m_last);
            cw = cpu_req && !ew;
`ifdef MEM_ARB_WRITE_BUF_EN
            cap = ew && cpu_req && cpu_we;
`else
            cap = 0;
`endif
            xwe = cw ? cpu_we : (ew && ext_we);
            chk("idle_we", mem_we, xwe); chk("idle_gnt", ext_gnt, ew);
            chk("idle_rvalid", ext_rvalid, 0);
            chk("idle_stall", cpu_stall, cpu_req && !(cw && cpu_we) && !cap);
            if (cw || ew) begin
                chk("idle_addr", mem_addr, cw ? cpu_addr : ext_addr);
                n_last = ew;
                if (xwe) begin
                    chk("idle_wdata", mem_wdata, cw ? cpu_wdata : ext_wdata);
                    n_w = 1; n_wa = cw ? cpu_addr[7:0] : ext_addr[7:0]; n_wd = cw ? cpu_wdata : ext_wdata;
                end else begin
                    n_pend = cw ? 1 : 2; n_ra = cw ? cpu_addr[7:0] : ext_addr[7:0];
                end
            end
            if (cap) begin n_bv = 1; n_ba = cpu_addr; n_bd = cpu_wdata; end
        end
    end
    always @(posedge clk) begin
        m_pend <= n_pend; m_last <= n_last; m_bv <= n_bv; m_ba <= n_ba; m_bd <= n_bd;
        m_fwd <= n_fwd; m_fd <= n_fd; m_ra <= n_ra;
        if (n_w) rmem[n_wa] <= n_wd;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ccnt, ecnt, ci, ei;
        rst = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 16'h1234;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
        @(negedge clk); chk("lit_rst_stall", cpu_stall, 0); chk("lit_rst_we", mem_we, 0);
        step();
        // lone CPU write then read-back of the same address
        rst = 1;
        @(negedge clk); chk("lit_w_we", mem_we, 1); chk("lit_w_addr", mem_addr, 16'h0010);
        chk("lit_w_data", mem_wdata, 16'h1234); chk("lit_w_stall", cpu_stall, 0);
        step();
        cpu_we = 0;
        @(negedge clk); chk("lit_r0_stall", cpu_stall, 1); chk("lit_r0_we", mem_we, 0);
        step();
        @(negedge clk); chk("lit_r1_data", cpu_rdata, 16'h1234); chk("lit_r1_stall", cpu_stall, 0);
        step();
        cpu_req = 0; rst = 0;
        step();
        // both read at reset release: CPU first, EXT granted two cycles later
        rst = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        ext_req = 1; ext_we = 0; ext_addr = 16'h0030;
        @(negedge clk); chk("lit_tie_gnt", ext_gnt, 0); chk("lit_tie_stall", cpu_stall, 1);
        step();
        @(negedge clk); chk("lit_tie_crd", cpu_rdata, 16'h1234); chk("lit_tie_gnt1", ext_gnt, 0);
        step();
        cpu_req = 0;
        @(negedge clk); chk("lit_tie_gnt2", ext_gnt, 1); chk("lit_tie_addr", mem_addr, 16'h0030);
        step();
        ext_req = 0;
        @(negedge clk); chk("lit_tie_rvalid", ext_rvalid, 1); chk("lit_tie_xrd", ext_rdata, 16'hA030);
        step();
`ifndef MEM_ARB_WRITE_BUF_EN
        // continuous write contention: strict alternation starting with CPU
        ccnt = 0; ecnt = 0; ci = 0; ei = 0;
        cpu_req = 1; cpu_we = 1; ext_req = 1; ext_we = 1;
        cpu_addr = 16'h0100; cpu_wdata = 16'hC000; ext_addr = 16'h0200; ext_wdata = 16'hE000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("lit_alt_gnt", ext_gnt, i % 2);
            if (ext_gnt) begin ecnt++; ei++; end
            if (!cpu_stall) begin ccnt++; ci++; end
            step();
            cpu_addr = 16'h0100 + 16'(ci); cpu_wdata = 16'hC000 + 16'(ci);
            ext_addr = 16'h0200 + 16'(ei); ext_wdata = 16'hE000 + 16'(ei);
        end
        chk("lit_alt_cpu_cnt", ccnt, 4); chk("lit_alt_ext_cnt", ecnt, 4);
        cpu_req = 0; ext_req = 0;
        step();
`endif
        // reset dropped during an external read data phase
        ext_req = 1; ext_we = 0; ext_addr = 16'h0040;
        @(negedge clk); chk("lit_xr_gnt", ext_gnt, 1);
        step();
        rst = 0; ext_req = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0050; cpu_wdata = 16'h5555;
        @(negedge clk); chk("lit_xr_rvalid", ext_rvalid, 0); chk("lit_xr_rdata", ext_rdata, 0);
        chk("lit_xr_stall", cpu_stall, 0); chk("lit_xr_we", mem_we, 0);
        step(); step();
        rst = 1; cpu_req = 0;
        @(negedge clk); chk("lit_rel_we", mem_we, 0); chk("lit_rel_rvalid", ext_rvalid, 0);
        step();
        cpu_req = 1; ext_req = 1; ext_we = 1; ext_addr = 16'h0060; ext_wdata = 16'h6666;
        @(negedge clk); chk("lit_rel_gnt", ext_gnt, 0); chk("lit_rel_addr", mem_addr, 16'h0050);
        step();
        cpu_req = 0;
        @(negedge clk); chk("lit_rel_gnt2", ext_gnt, 1);
        step();
        ext_req = 0;
        step();
`ifdef MEM_ARB_WRITE_BUF_EN
        // posted CPU write losing a tie, drained next cycle, then forwarded to a read
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0070; cpu_wdata = 16'h7777;
        step();
        cpu_addr = 16'h0020; cpu_wdata = 16'hBEEF;
        ext_req = 1; ext_we = 1; ext_addr = 16'h0080; ext_wdata = 16'h8888;
        @(negedge clk); chk("lit_wb_gnt", ext_gnt, 1); chk("lit_wb_stall", cpu_stall, 0);
        chk("lit_wb_addr", mem_addr, 16'h0080);
        step();
        ext_req = 0; cpu_we = 0;
        @(negedge clk); chk("lit_wb_drain_we", mem_we, 1); chk("lit_wb_drain_addr", mem_addr, 16'h0020);
        chk("lit_wb_drain_data", mem_wdata, 16'hBEEF); chk("lit_wb_drain_stall", cpu_stall, 1);
        step();
        @(negedge clk); chk("lit_wb_fwd", cpu_rdata, 16'hBEEF); chk("lit_wb_fwd_stall", cpu_stall, 0);
        step();
        cpu_req = 0;
        step();
`endif
        // back-to-back CPU reads run at one per two cycles
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("lit_b2b_stall", cpu_stall, (i % 2) == 0);
            step();
        end
        cpu_req = 0;
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
